conv_seq_ctrl: RTL and testbench

Sequencing controller for the convolution AIP datapath: z[n] = sum over k of x[k]*y[n-k], for n = 0 .. SIZEX+SIZEY-2.
- Generates read addresses for the X and Y input memories.
- Drives the clear and enable strobes of the external MAC accumulator.
- Issues output-memory write strobes and the done pulse.
- Sits between the AIP register/start interface and the MAC plus memory datapath.

---
 rtl/conv_pkg.sv | 44 ++++
 rtl/conv_bounds.sv | 61 ++++++
 rtl/conv_seq_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution AIP sequencing controller:
//   - default size-field width
//   - bit offsets of the SIZEX / SIZEY fields in the config register
//   - register ID constants shared with the AIP register interface
//   - FSM state encodings and the state enum built on them
// Optional feature macro used by conv_seq_ctrl: CONV_SEQ_CYCLE_CNT_EN
// -----------------------------------------------------------------------------
package conv_pkg;

    // Default width of each size field and of the X/Y address buses.
    localparam int CONV_SIZE_W = 5;

    // Field offsets inside the config register.
    localparam int SIZEX_LSB = 0;
    localparam int SIZEY_LSB = 5;

    // Register IDs shared with the AIP register/start interface.
    localparam logic [3:0] CONV_REG_ID_MEM_X  = 4'h0;
    localparam logic [3:0] CONV_REG_ID_MEM_Y  = 4'h1;
    localparam logic [3:0] CONV_REG_ID_MEM_Z  = 4'h2;
    localparam logic [3:0] CONV_REG_ID_CONFIG = 4'h3;
    localparam logic [3:0] CONV_REG_ID_STATUS = 4'h4;
    localparam logic [3:0] CONV_REG_ID_CYCLES = 4'h5;

    // Fixed state encodings, kept stable so external debug tooling can decode them.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        SETUP = ST_SETUP,
        ISSUE = ST_ISSUE,
        DRAIN = ST_DRAIN,
        WRITE = ST_WRITE,
        DONE  = ST_DONE
    } conv_state_e;

endpackage

// File: rtl/conv_bounds.sv
// -----------------------------------------------------------------------------
// conv_bounds
// Combinational summation bounds for output index n of z[n] = sum x[k]*y[n-k]:
//   kmin(n) = max(0, n - size_y + 1)
//   kmax(n) = min(n, size_x - 1)
// Ports:
//   n_i       output index currently being computed
//   size_x_i  latched SIZEX (must be non-zero when the result is used)
//   size_y_i  latched SIZEY (must be non-zero when the result is used)
//   kmin_o    first k of the sum for n
//   kmax_o    last k of the sum for n
// -----------------------------------------------------------------------------
module conv_bounds
    import conv_pkg::*;
#(
    parameter int SIZE_W = CONV_SIZE_W,
    parameter int OUT_AW = SIZE_W + 1
) (
    input  logic [OUT_AW-1:0] n_i,
    input  logic [SIZE_W-1:0] size_x_i,
    input  logic [SIZE_W-1:0] size_y_i,
    output logic [SIZE_W-1:0] kmin_o,
    output logic [SIZE_W-1:0] kmax_o
);

    // One bit wider than n so that n + 1 - size_y is evaluated without wrap.
    localparam int BW = OUT_AW + 1;

    logic [BW-1:0] n_w;
    logic [BW-1:0] sx_w;
    logic [BW-1:0] sy_w;
    logic [BW-1:0] lo_w;
    logic [BW-1:0] hi_w;
    logic          bounds_unused;

    always_comb begin
        n_w  = BW'(n_i);
        sx_w = BW'(size_x_i);
        sy_w = BW'(size_y_i);

        // Compare n + 1 against size_y rather than subtracting first.
        if ((n_w + BW'(1)) > sy_w) begin
            lo_w = n_w + BW'(1) - sy_w;
        end else begin
            lo_w = '0;
        end

        if (n_w < (sx_w - BW'(1))) begin
            hi_w = n_w;
        end else begin
            hi_w = sx_w - BW'(1);
        end
    end

    // Both bounds are always below 2^SIZE_W for legal sizes.
    assign kmin_o = lo_w[SIZE_W-1:0];
    assign kmax_o = hi_w[SIZE_W-1:0];

    assign bounds_unused = ^{lo_w[BW-1:SIZE_W], hi_w[BW-1:SIZE_W]};

endmodule

// File: rtl/conv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// conv_seq_ctrl
// Sequencing controller for the convolution AIP datapath.
// For every output n it clears the external MAC, issues one X/Y read per term
// k = kmin(n)..kmax(n), lets the last product drain through the one-cycle
// memory latency, then writes z[n]. A done pulse ends the run.
//
// Optional feature macro: CONV_SEQ_CYCLE_CNT_EN
//   defined   -> cycle_cnt counts en_s-qualified busy cycles (saturating)
//   undefined -> cycle_cnt is tied to 0
//
// Ports:
//   clk        system clock
//   rst_a      asynchronous reset, active-high
//   en_s       synchronous enable; low freezes all state and zeroes strobes
//   start      start pulse, only accepted in IDLE
//   size_x     SIZEX (number of X samples)
//   size_y     SIZEY (number of Y samples)
//   rd_en      X/Y memory read strobe
//   addr_x     X memory address (k)
//   addr_y     Y memory address (n-k)
//   mac_clr    clear accumulator
//   mac_en     accumulate product (rd_en delayed by one enabled cycle)
//   wr_out     output memory write strobe
//   addr_out   output memory address (n)
//   busy       high in any state other than IDLE
//   done       one-cycle completion pulse
//   cfg_err    zero size seen; sticky until the next accepted start
//   cycle_cnt  busy-cycle counter
//
// Handshake: start is a level sampled on enabled clock edges while IDLE; there
// is no back-pressure, every strobe is valid for exactly one enabled cycle.
// -----------------------------------------------------------------------------
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int SIZE_W = CONV_SIZE_W,
    parameter int OUT_AW = SIZE_W + 1
) (
    input  logic              clk,
    input  logic              rst_a,
    input  logic              en_s,
    input  logic              start,
    input  logic [SIZE_W-1:0] size_x,
    input  logic [SIZE_W-1:0] size_y,
    output logic              rd_en,
    output logic [SIZE_W-1:0] addr_x,
    output logic [SIZE_W-1:0] addr_y,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              wr_out,
    output logic [OUT_AW-1:0] addr_out,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [15:0]       cycle_cnt
);

    conv_state_e       state_q, state_d;
    logic [OUT_AW-1:0] n_q, n_d;
    logic [OUT_AW-1:0] ntot_q, ntot_d;
    logic [SIZE_W-1:0] sx_q, sx_d;
    logic [SIZE_W-1:0] sy_q, sy_d;
    // addr_x_q doubles as the term index k; addr_y_q tracks n - k alongside it.
    logic [SIZE_W-1:0] addr_x_q, addr_x_d;
    logic [SIZE_W-1:0] addr_y_q, addr_y_d;
    logic [OUT_AW-1:0] addr_out_q, addr_out_d;
    logic              cfg_err_q, cfg_err_d;
    logic              mac_en_q;

    logic              rd_raw;
    logic              clr_raw;
    logic              wr_raw;
    logic              done_raw;
    logic [SIZE_W-1:0] kmin;
    logic [SIZE_W-1:0] kmax;
    logic [OUT_AW-1:0] y_diff;
    logic              ctrl_unused;

    conv_bounds #(
        .SIZE_W (SIZE_W),
        .OUT_AW (OUT_AW)
    ) u_bounds (
        .n_i      (n_q),
        .size_x_i (sx_q),
        .size_y_i (sy_q),
        .kmin_o   (kmin),
        .kmax_o   (kmax)
    );

    // n - kmin(n) is at most size_y - 1, so the low SIZE_W bits carry it all.
    assign y_diff      = n_q - OUT_AW'(kmin);
    assign ctrl_unused = ^y_diff[OUT_AW-1:SIZE_W];

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        ntot_d     = ntot_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        addr_x_d   = addr_x_q;
        addr_y_d   = addr_y_q;
        addr_out_d = addr_out_q;
        cfg_err_d  = cfg_err_q;
        rd_raw     = 1'b0;
        clr_raw    = 1'b0;
        wr_raw     = 1'b0;
        done_raw   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sx_d      = size_x;
                    sy_d      = size_y;
                    ntot_d    = OUT_AW'(size_x) + OUT_AW'(size_y) - OUT_AW'(1);
                    cfg_err_d = 1'b0;
                    if ((size_x == '0) || (size_y == '0)) begin
                        cfg_err_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        n_d     = '0;
                        state_d = SETUP;
                    end
                end
            end

            SETUP: begin
                clr_raw  = 1'b1;
                addr_x_d = kmin;
                addr_y_d = y_diff[SIZE_W-1:0];
                state_d  = ISSUE;
            end

            ISSUE: begin
                rd_raw = 1'b1;
                if (addr_x_q == kmax) begin
                    state_d = DRAIN;
                end else begin
                    addr_x_d = addr_x_q + SIZE_W'(1);
                    addr_y_d = addr_y_q - SIZE_W'(1);
                end
            end

            DRAIN: begin
                // Load the write address here so it holds between writes.
                addr_out_d = n_q;
                state_d    = WRITE;
            end

            WRITE: begin
                wr_raw = 1'b1;
                if (n_q == (ntot_q - OUT_AW'(1))) begin
                    state_d = DONE;
                end else begin
                    n_d     = n_q + OUT_AW'(1);
                    state_d = SETUP;
                end
            end

            DONE: begin
                done_raw = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q    <= IDLE;
            n_q        <= '0;
            ntot_q     <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            addr_x_q   <= '0;
            addr_y_q   <= '0;
            addr_out_q <= '0;
            cfg_err_q  <= 1'b0;
            mac_en_q   <= 1'b0;
        end else if (en_s) begin
            state_q    <= state_d;
            n_q        <= n_d;
            ntot_q     <= ntot_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            addr_x_q   <= addr_x_d;
            addr_y_q   <= addr_y_d;
            addr_out_q <= addr_out_d;
            cfg_err_q  <= cfg_err_d;
            // Product is available one enabled cycle after its read.
            mac_en_q   <= rd_raw;
        end
    end

    assign rd_en    = rd_raw & en_s;
    assign mac_clr  = clr_raw & en_s;
    assign wr_out   = wr_raw & en_s;
    assign done     = done_raw & en_s;
    assign mac_en   = mac_en_q & en_s;
    assign addr_x   = addr_x_q;
    assign addr_y   = addr_y_q;
    assign addr_out = addr_out_q;
    assign busy     = (state_q != IDLE);
    assign cfg_err  = cfg_err_q;

`ifdef CONV_SEQ_CYCLE_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            cnt_q <= '0;
        end else if (en_s) begin
            if (state_q == IDLE) begin
                if (start) begin
                    cnt_q <= '0;
                end
            end else if (cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign cycle_cnt = cnt_q;
`else
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
module tb_conv_seq_ctrl;

  localparam int SW  = 5;
  localparam int OAW = 6;

  logic           clk = 1'b0;
  logic           rst_a;
  logic           en_s;
  logic           start;
  logic [SW-1:0]  size_x;
  logic [SW-1:0]  size_y;
  logic           rd_en;
  logic [SW-1:0]  addr_x;
  logic [SW-1:0]  addr_y;
  logic           mac_clr;
  logic           mac_en;
  logic           wr_out;
  logic [OAW-1:0] addr_out;
  logic           busy;
  logic           done;
  logic           cfg_err;
  logic [15:0]    cycle_cnt;

  int total = 0;
  int bad   = 0;

  // Expected read pairs {addr_x, addr_y} and write addresses, in issue order.
  logic [2*SW-1:0] exp_rd_q[$];
  logic [OAW-1:0]  exp_wr_q[$];

  logic [SW-1:0]  last_x   = '0;
  logic [SW-1:0]  last_y   = '0;
  logic [OAW-1:0] last_out = '0;
  logic           prev_rd  = 1'b0;

  conv_seq_ctrl dut (
    .clk       (clk),
    .rst_a     (rst_a),
    .en_s      (en_s),
    .start     (start),
    .size_x    (size_x),
    .size_y    (size_y),
    .rd_en     (rd_en),
    .addr_x    (addr_x),
    .addr_y    (addr_y),
    .mac_clr   (mac_clr),
    .mac_en    (mac_en),
    .wr_out    (wr_out),
    .addr_out  (addr_out),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .cycle_cnt (cycle_cnt)
  );

  // clock
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: enumerate every (k, n-k) term of every output n directly.
  task automatic build_model(input int sx, input int sy);
    int lo;
    int hi;
    exp_rd_q.delete();
    exp_wr_q.delete();
    if (sx != 0 && sy != 0) begin
      for (int n = 0; n <= sx + sy - 2; n++) begin
        lo = (n - sy + 1 > 0) ? n - sy + 1 : 0;
        hi = (n < sx - 1) ? n : sx - 1;
        for (int k = lo; k <= hi; k++) begin
          exp_rd_q.push_back({SW'(k), SW'(n - k)});
        end
        exp_wr_q.push_back(OAW'(n));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_strobes"}, {rd_en, mac_clr, mac_en, wr_out, done, busy, cfg_err}, 0);
    chk({tag, "_addr"}, {addr_x, addr_y, addr_out}, 0);
    chk({tag, "_cnt"}, cycle_cnt, 0);
  endtask

  // One complete run: start edge is cycle 0, cycle c is sampled after edge c-1.
  task automatic run_seq(input int sx, input int sy, input int gap_at,
                         input bit poke_busy, input bit poke_done);
    bit              err;
    bit              en;
    bit              seen;
    int              n_tot;
    int              base;
    int              exp_done;
    int              c;
    int              rd_cnt;
    int              men_cnt;
    int              clr_cnt;
    int              wr_cnt;
    logic [2*SW-1:0] e_rd;
    logic [OAW-1:0]  e_wr;

    build_model(sx, sy);
    err      = (sx == 0) || (sy == 0);
    n_tot    = err ? 0 : sx + sy - 1;
    base     = err ? 1 : sx * sy + 3 * n_tot + 1;
    exp_done = base + ((gap_at > 0 && gap_at < base) ? 3 : 0);
    rd_cnt   = 0;
    men_cnt  = 0;
    clr_cnt  = 0;
    wr_cnt   = 0;
    seen     = 1'b0;
    c        = 0;

    @(negedge clk);
    size_x  = SW'(sx);
    size_y  = SW'(sy);
    start   = 1'b1;
    en_s    = 1'b1;
    prev_rd = 1'b0;

    while (!seen && c < base + 60) begin
      @(negedge clk);
      c++;
      en     = !(gap_at > 0 && c >= gap_at && c < gap_at + 3);
      en_s   = en;
      start  = (poke_busy && c == 3) || (poke_done && c == exp_done);
      size_x = SW'($urandom_range(0, 31));
      size_y = SW'($urandom_range(0, 31));
      #1;
      if (!en) chk("gated_strobes", {rd_en, mac_en, mac_clr, wr_out, done}, 0);
      chk("mac_en_pipe", mac_en, prev_rd & en);
      if (en) prev_rd = rd_en;
      chk("busy_run", busy, 1);
      if (c == 1) chk("cfg_err_c1", cfg_err, err);
      if (rd_en) begin
        rd_cnt++;
        e_rd = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : '1;
        chk("rd_addr", {addr_x, addr_y}, e_rd);
        last_x = addr_x;
        last_y = addr_y;
      end else if (en) begin
        chk("addr_hold", {addr_x, addr_y}, {last_x, last_y});
      end
      if (mac_en) men_cnt++;
      if (mac_clr) clr_cnt++;
      if (wr_out) begin
        wr_cnt++;
        chk("clr_per_group", clr_cnt, wr_cnt);
        e_wr = (exp_wr_q.size() > 0) ? exp_wr_q.pop_front() : '1;
        chk("wr_addr", addr_out, e_wr);
        last_out = addr_out;
      end else if (en) begin
        chk("out_hold", addr_out, last_out);
      end
      if (done) begin
        seen = 1'b1;
        chk("done_cycle", c, exp_done);
        chk("cfg_err_done", cfg_err, err);
      end
    end
    chk("done_seen", seen, 1);
    chk("rd_count", rd_cnt, sx * sy);
    chk("mac_en_count", men_cnt, sx * sy);
    chk("clr_count", clr_cnt, n_tot);
    chk("wr_count", wr_cnt, n_tot);

    @(negedge clk);
    start = 1'b0;
    en_s  = 1'b1;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_cfg_err", cfg_err, err);
`ifdef CONV_SEQ_CYCLE_CNT_EN
    chk("cycle_cnt", cycle_cnt, base);
`else
    chk("cycle_cnt", cycle_cnt, 0);
`endif
  endtask

  task automatic reset_mid(input int sx, input int sy, input int at);
    @(negedge clk);
    size_x = SW'(sx);
    size_y = SW'(sy);
    start  = 1'b1;
    en_s   = 1'b1;
    for (int i = 1; i <= at; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    chk("pre_reset_rd", rd_en, 1);
    rst_a = 1'b1;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a    = 1'b0;
    last_x   = '0;
    last_y   = '0;
    last_out = '0;
  endtask

  initial begin
    int sx;
    int sy;
    int g;

    // reset
    rst_a  = 1'b1;
    en_s   = 1'b0;
    start  = 1'b0;
    size_x = '0;
    size_y = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_a = 1'b0;
    en_s  = 1'b1;

    // directed scenarios
    run_seq(5, 10, 0, 0, 0);
    run_seq(3, 2, 0, 0, 0);
    run_seq(1, 1, 0, 0, 0);
    run_seq(0, 4, 0, 0, 1);
    run_seq(2, 3, 0, 0, 0);
    run_seq(31, 31, 0, 0, 0);
    run_seq(5, 10, 12, 1, 0);
    reset_mid(5, 10, 12);
    run_seq(5, 10, 0, 0, 0);

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      sx = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 31);
      sy = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 31);
      g  = ($urandom_range(0, 1) == 1 && sx != 0 && sy != 0) ? $urandom_range(2, sx * sy) : 0;
      run_seq(sx, sy, g, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
